// File: rtl/btb_assoc_array_if.sv
// BTB storage-array port bundle: IF-stage lookup, EX-stage update/victim, writes, touches and flush.
// Reads are combinational. Writes, touches and flush requests are sampled at the clock edge, with no handshake.
interface btb_assoc_array_if #(
  parameter int NUM_SETS = 8,
  parameter int WAYS     = 2,
  parameter int TAG_W    = 27,
  parameter int TGT_W    = 32,
  parameter int CTR_W    = 2
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic [IDX_W-1:0]      rd_index;
  logic [WAYS-1:0]       rd_valid;
  logic [WAYS*TAG_W-1:0] rd_tag;
  logic [WAYS*TGT_W-1:0] rd_target;
  logic [WAYS*CTR_W-1:0] rd_ctr;

  logic [IDX_W-1:0]      upd_index;
  logic [WAYS-1:0]       upd_valid;
  logic [WAYS*TAG_W-1:0] upd_tag;
  logic [WAYS*CTR_W-1:0] upd_ctr;
  logic [WAY_W-1:0]      upd_victim;

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_index;
  logic [WAY_W-1:0]      wr_way;
  logic                  wr_valid;
  logic [TAG_W-1:0]      wr_tag;
  logic [TGT_W-1:0]      wr_target;
  logic [CTR_W-1:0]      wr_ctr;

  logic                  touch_en;
  logic [IDX_W-1:0]      touch_index;
  logic [WAY_W-1:0]      touch_way;

  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;

  modport master (
    output rd_index, upd_index,
    output wr_en, wr_index, wr_way, wr_valid, wr_tag, wr_target, wr_ctr,
    output touch_en, touch_index, touch_way, flush_req,
    input  rd_valid, rd_tag, rd_target, rd_ctr,
    input  upd_valid, upd_tag, upd_ctr, upd_victim,
    input  flush_busy, flush_done
  );

  modport slave (
    input  rd_index, upd_index,
    input  wr_en, wr_index, wr_way, wr_valid, wr_tag, wr_target, wr_ctr,
    input  touch_en, touch_index, touch_way, flush_req,
    output rd_valid, rd_tag, rd_target, rd_ctr,
    output upd_valid, upd_tag, upd_ctr, upd_victim,
    output flush_busy, flush_done
  );
endinterface

// File: rtl/btb_assoc_array.sv
// N-way set-associative BTB array with tree pseudo-LRU replacement and a one-set-per-cycle flush sequencer.
// Reads are zero latency, with rd_* bypassing a same-cycle write. Writes and touches are dropped while a flush runs.
module btb_assoc_array #(
  parameter int NUM_SETS = 8,
  parameter int WAYS     = 2,
  parameter int TAG_W    = 27,
  parameter int TGT_W    = 32,
  parameter int CTR_W    = 2
) (
  input logic               clk,
  input logic               rst,
  btb_assoc_array_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(NUM_SETS - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             idle;
  logic             wr_go;
  logic             touch_go;

  logic [WAYS-1:0]  valid_q [NUM_SETS];
  logic [WAYS-2:0]  plru_q  [NUM_SETS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][WAYS];
  logic [TGT_W-1:0] tgt_q   [NUM_SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [NUM_SETS][WAYS];

  // Tree nodes are heap ordered: node n has its left child at 2n+1 and its right child at 2n+2.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  nb;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] w;
    logic             dir;
    nb   = bits;
    node = '0;
    w    = way;
    for (int l = 0; l < WAY_W; l++) begin
      dir      = w[WAY_W-1];
      nb[node] = ~dir;
      node     = WAY_W'((int'(node) << 1) + 1 + int'(dir));
      w        = w << 1;
    end
    return nb;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] v;
    logic             b;
    node = '0;
    v    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = bits[node];
      v    = WAY_W'({v, b});
      node = WAY_W'((int'(node) << 1) + 1 + int'(b));
    end
    return v;
  endfunction

  assign idle     = (state_q == IDLE);
  assign wr_go    = bus.wr_en && idle;
  assign touch_go = bus.touch_en && idle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.flush_busy = 1'b0;
    bus.flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        bus.flush_busy = 1'b1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.flush_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid and PLRU state. When touch and write hit the same set, the later touch assignment wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[cnt_q[IDX_W-1:0]] <= '0;
      plru_q[cnt_q[IDX_W-1:0]]  <= '0;
    end else begin
      if (wr_go) begin
        valid_q[bus.wr_index][bus.wr_way] <= bus.wr_valid;
        plru_q[bus.wr_index] <= plru_touch(plru_q[bus.wr_index], bus.wr_way);
      end
      if (touch_go) begin
        plru_q[bus.touch_index] <= plru_touch(plru_q[bus.touch_index], bus.touch_way);
      end
    end
  end

  // Payload fields are meaningless while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      tag_q[bus.wr_index][bus.wr_way] <= bus.wr_tag;
      tgt_q[bus.wr_index][bus.wr_way] <= bus.wr_target;
      ctr_q[bus.wr_index][bus.wr_way] <= bus.wr_ctr;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic byp;
    assign byp = wr_go && (bus.wr_index == bus.rd_index) && (bus.wr_way == WAY_W'(w));

    assign bus.rd_valid[w] = idle && (byp ? bus.wr_valid : valid_q[bus.rd_index][w]);
    assign bus.rd_tag[w*TAG_W +: TAG_W]    = byp ? bus.wr_tag    : tag_q[bus.rd_index][w];
    assign bus.rd_target[w*TGT_W +: TGT_W] = byp ? bus.wr_target : tgt_q[bus.rd_index][w];
    assign bus.rd_ctr[w*CTR_W +: CTR_W]    = byp ? bus.wr_ctr    : ctr_q[bus.rd_index][w];

    assign bus.upd_valid[w] = idle && valid_q[bus.upd_index][w];
    assign bus.upd_tag[w*TAG_W +: TAG_W] = tag_q[bus.upd_index][w];
    assign bus.upd_ctr[w*CTR_W +: CTR_W] = ctr_q[bus.upd_index][w];
  end

  assign bus.upd_victim = plru_victim(plru_q[bus.upd_index]);

endmodule

// File: tb/tb_btb_assoc_array.sv
// Directed bench for btb_assoc_array (8 sets, 2 ways): vector table plus flush and reset-abort sequences.
module tb_btb_assoc_array;
  localparam int TAG_W = 27;
  localparam int TGT_W = 32;
  localparam int CTR_W = 2;

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  btb_assoc_array_if bus ();
  btb_assoc_array dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic        wr_way;
    logic        wr_vld;
    logic [26:0] wr_tag;
    logic [31:0] wr_tgt;
    logic [1:0]  wr_ctr;
    logic        t_en;
    logic [2:0]  t_idx;
    logic        t_way;
    logic [2:0]  rd_idx;
    logic [2:0]  upd_idx;
    logic [1:0]  e_rd_vld;
    logic [1:0]  e_upd_vld;
    logic        e_victim;
    logic        dat_way;
    logic [26:0] e_tag;
    logic [31:0] e_tgt;
    logic [1:0]  e_ctr;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en       = 1'b0;
    bus.wr_index    = '0;
    bus.wr_way      = '0;
    bus.wr_valid    = 1'b0;
    bus.wr_tag      = '0;
    bus.wr_target   = '0;
    bus.wr_ctr      = '0;
    bus.touch_en    = 1'b0;
    bus.touch_index = '0;
    bus.touch_way   = '0;
    bus.flush_req   = 1'b0;
  endtask

  task automatic fill_all();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        tick();
        bus.wr_en     = 1'b1;
        bus.wr_index  = 3'(s);
        bus.wr_way    = 1'(w);
        bus.wr_valid  = 1'b1;
        bus.wr_tag    = 27'(s * 16 + w);
        bus.wr_target = 32'(s * 256 + w);
        bus.wr_ctr    = 2'(w);
      end
    end
    tick();
    idle_in();
  endtask

  task automatic chk_all_valid(input string nm, input logic [1:0] exp);
    for (int s = 0; s < 8; s++) begin
      bus.upd_index = 3'(s);
      bus.rd_index  = 3'(s);
      #1;
      chk($sformatf("%s upd_valid set%0d", nm, s), 64'(bus.upd_valid), 64'(exp));
      chk($sformatf("%s rd_valid set%0d", nm, s), 64'(bus.rd_valid), 64'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 1'b1, 1'b1, 27'h1234, 32'h8000_0040, 2'd2, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3,
                2'b10, 2'b00, 1'b0, 1'b1, 27'h1234, 32'h8000_0040, 2'd2};
    tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3,
                2'b10, 2'b10, 1'b0, 1'b1, 27'h1234, 32'h8000_0040, 2'd2};
    tbl[2]  = '{1'b1, 3'd5, 1'b0, 1'b1, 27'h55, 32'h100, 2'd1, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5,
                2'b01, 2'b00, 1'b0, 1'b0, 27'h55, 32'h100, 2'd1};
    tbl[3]  = '{1'b1, 3'd5, 1'b1, 1'b1, 27'h66, 32'h200, 2'd3, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5,
                2'b11, 2'b01, 1'b1, 1'b1, 27'h66, 32'h200, 2'd3};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b1, 3'd5, 1'b0, 3'd5, 3'd5,
                2'b11, 2'b11, 1'b0, 1'b0, 27'h55, 32'h100, 2'd1};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5,
                2'b11, 2'b11, 1'b1, 1'b1, 27'h66, 32'h200, 2'd3};
    tbl[6]  = '{1'b1, 3'd2, 1'b0, 1'b1, 27'h22, 32'h300, 2'd0, 1'b1, 3'd2, 1'b1, 3'd2, 3'd2,
                2'b01, 2'b00, 1'b0, 1'b0, 27'h22, 32'h300, 2'd0};
    tbl[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2,
                2'b01, 2'b01, 1'b0, 1'b0, 27'h22, 32'h300, 2'd0};
    tbl[8]  = '{1'b1, 3'd3, 1'b1, 1'b0, 27'h7, 32'h0, 2'd1, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3,
                2'b00, 2'b10, 1'b0, 1'b1, 27'h7, 32'h0, 2'd1};
    tbl[9]  = '{1'b1, 3'd6, 1'b1, 1'b1, 27'h99, 32'h400, 2'd2, 1'b1, 3'd5, 1'b1, 3'd6, 3'd5,
                2'b10, 2'b11, 1'b1, 1'b1, 27'h99, 32'h400, 2'd2};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd6, 3'd5,
                2'b10, 2'b11, 1'b0, 1'b1, 27'h99, 32'h400, 2'd2};
    tbl[11] = '{1'b1, 3'd0, 1'b0, 1'b1, 27'hA, 32'h500, 2'd3, 1'b0, 3'd0, 1'b0, 3'd6, 3'd6,
                2'b10, 2'b10, 1'b0, 1'b1, 27'h99, 32'h400, 2'd2};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 27'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd3,
                2'b01, 2'b00, 1'b0, 1'b0, 27'hA, 32'h500, 2'd3};

    idle_in();
    bus.rd_index  = '0;
    bus.upd_index = '0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset flush_busy", 64'(bus.flush_busy), 64'd0);
    chk("reset flush_done", 64'(bus.flush_done), 64'd0);
    chk_all_valid("reset", 2'b00);

    // Table: vector i is driven for one cycle, checked before its edge, committed at the edge
    for (int i = 0; i < NV; i++) begin
      int dw;
      tick();
      bus.wr_en       = tbl[i].wr_en;
      bus.wr_index    = tbl[i].wr_idx;
      bus.wr_way      = tbl[i].wr_way;
      bus.wr_valid    = tbl[i].wr_vld;
      bus.wr_tag      = tbl[i].wr_tag;
      bus.wr_target   = tbl[i].wr_tgt;
      bus.wr_ctr      = tbl[i].wr_ctr;
      bus.touch_en    = tbl[i].t_en;
      bus.touch_index = tbl[i].t_idx;
      bus.touch_way   = tbl[i].t_way;
      bus.rd_index    = tbl[i].rd_idx;
      bus.upd_index   = tbl[i].upd_idx;
      @(negedge clk);
      dw = int'(tbl[i].dat_way);
      chk($sformatf("v%0d rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rd_vld));
      chk($sformatf("v%0d upd_valid", i), 64'(bus.upd_valid), 64'(tbl[i].e_upd_vld));
      chk($sformatf("v%0d upd_victim", i), 64'(bus.upd_victim), 64'(tbl[i].e_victim));
      chk($sformatf("v%0d rd_tag", i), 64'(bus.rd_tag[dw*TAG_W +: TAG_W]), 64'(tbl[i].e_tag));
      chk($sformatf("v%0d rd_target", i), 64'(bus.rd_target[dw*TGT_W +: TGT_W]), 64'(tbl[i].e_tgt));
      chk($sformatf("v%0d rd_ctr", i), 64'(bus.rd_ctr[dw*CTR_W +: CTR_W]), 64'(tbl[i].e_ctr));
    end
    tick();
    idle_in();
    bus.upd_index = 3'd6;
    @(negedge clk);
    chk("upd_tag set6 way1", 64'(bus.upd_tag[1*TAG_W +: TAG_W]), 64'h99);
    chk("upd_ctr set6 way1", 64'(bus.upd_ctr[1*CTR_W +: CTR_W]), 64'd2);

    // Full flush: busy for 8 cycles, done in cycle 9, writes during busy are lost
    fill_all();
    @(negedge clk);
    chk_all_valid("filled", 2'b11);
    tick();
    bus.flush_req = 1'b1;
    @(negedge clk);
    chk("pre-flush busy", 64'(bus.flush_busy), 64'd0);
    tick();
    idle_in();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) bus.rd_index = 3'd7;
      if (cyc == 3) bus.flush_req = 1'b1;
      if (cyc == 5) begin
        bus.wr_en    = 1'b1;
        bus.wr_index = 3'd0;
        bus.wr_way   = 1'b0;
        bus.wr_valid = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("flush c%0d busy", cyc), 64'(bus.flush_busy), 64'(cyc <= 8));
      chk($sformatf("flush c%0d done", cyc), 64'(bus.flush_done), 64'(cyc == 9));
      if (cyc == 2) chk("flush rd_valid forced", 64'(bus.rd_valid), 64'd0);
      tick();
      idle_in();
    end
    @(negedge clk);
    chk_all_valid("flushed", 2'b00);

    // Reset during flush cycle 4 aborts it without a done pulse
    fill_all();
    tick();
    bus.flush_req = 1'b1;
    tick();
    idle_in();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc == 4) rst = 1'b0;
      @(negedge clk);
      chk($sformatf("abort c%0d busy", cyc), 64'(bus.flush_busy), 64'd1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort c5 busy", 64'(bus.flush_busy), 64'd0);
    chk("abort c5 done", 64'(bus.flush_done), 64'd0);
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        @(negedge clk);
        if (bus.flush_done) pulses++;
      end
      chk("abort done pulses", 64'(pulses), 64'd0);
    end
    chk_all_valid("aborted", 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
